// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issuer.
// Opcodes, ALU control codes and FSM states.
package alu_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_CMPEQ = 2'b10;

    localparam logic [3:0] ALUC_ADD = 4'd0;
    localparam logic [3:0] ALUC_SUB = 4'd1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder.
// Maps a request opcode to an ALU control code.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] op,
    output logic [3:0] ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = ALUC_ADD;
        illegal = 1'b0;
        case (op)
            OP_ADD:   ctrl = ALUC_ADD;
            OP_SUB:   ctrl = ALUC_SUB;
            OP_CMPEQ: ctrl = ALUC_SUB;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issuer.sv
// Issues one request at a time to a multi-cycle ALU.
// Waits the settle time, then presents the captured result.
module alu_issuer
    import alu_pkg::*;
#(
    parameter int WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [1:0]  req_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_res,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_res,
    output logic        rsp_zero,
    output logic        rsp_err
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  dec_ctrl;
    logic        dec_illegal;
    logic        accept;

    alu_op_decode u_dec (
        .op      (req_op),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = dec_illegal ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            alu_a    <= 32'd0;
            alu_b    <= 32'd0;
            alu_ctrl <= ALUC_ADD;
            rsp_res  <= 32'd0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_a    <= req_a;
                alu_b    <= req_b;
                alu_ctrl <= dec_ctrl;
                if (dec_illegal) begin
                    rsp_err  <= 1'b1;
                    rsp_res  <= 32'd0;
                    rsp_zero <= 1'b0;
                end else begin
                    cnt_q <= CNT_LOAD;
                end
            end
            // Result is sampled only once the ALU has settled.
            if (state_q == WAIT) begin
                if (cnt_q == 4'd0) begin
                    rsp_res  <= alu_res;
                    rsp_zero <= alu_zero;
                    rsp_err  <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issuer.sv
// Directed self-checking bench for alu_issuer.
// A behavioural ALU answers the issuer's operand outputs.
module tb_alu_issuer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_res;
    logic        rsp_zero;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        alu_res  = (alu_ctrl == 4'd1) ? alu_a - alu_b : alu_a + alu_b;
        alu_zero = (alu_a == alu_b);
    end

    alu_issuer #(.WAIT_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_res   (alu_res),
        .alu_zero  (alu_zero),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Latency counted in edges from the accept edge; 40 means timeout.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if ({alu_a, alu_b, alu_ctrl, rsp_res} !== 100'd0) begin
            $display("FAIL reset_data: got %h %h %h %h want 0",
                     alu_a, alu_b, alu_ctrl, rsp_res);
            n_fail++;
        end
        n_checks++;
        if ({rsp_valid, rsp_zero, rsp_err, req_ready} !== 4'b0001) begin
            $display("FAIL reset_ctl: got v%b z%b e%b r%b want v0 z0 e0 r1",
                     rsp_valid, rsp_zero, rsp_err, req_ready);
            n_fail++;
        end
    endtask

    task automatic test_add();
        int lat;
        issue(32'd5, 32'd7, 2'b00);
        n_checks++;
        if (alu_ctrl !== 4'd0 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
            $display("FAIL add_drive: got ctrl %0d a %0d b %0d want 0 5 7",
                     alu_ctrl, alu_a, alu_b);
            n_fail++;
        end
        wait_rsp(lat);
        n_checks++;
        if (lat !== 5) begin
            $display("FAIL add_latency: got %0d want 5", lat);
            n_fail++;
        end
        n_checks++;
        if (rsp_res !== 32'd12 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
            $display("FAIL add_rsp: got %0d z%b e%b want 12 z0 e0",
                     rsp_res, rsp_zero, rsp_err);
            n_fail++;
        end
        handshake();
    endtask

    task automatic test_cmpeq_stall();
        int lat;
        issue(32'h1234, 32'h1234, 2'b10);
        n_checks++;
        if (alu_ctrl !== 4'd1) begin
            $display("FAIL cmpeq_ctrl: got %0d want 1", alu_ctrl);
            n_fail++;
        end
        wait_rsp(lat);
        n_checks++;
        if (lat !== 5) begin
            $display("FAIL cmpeq_latency: got %0d want 5", lat);
            n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_res !== 32'd0 ||
                rsp_zero !== 1'b1 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                $display("FAIL cmpeq_hold%0d: got v%b %h z%b e%b r%b want v1 0 z1 e0 r0",
                         i, rsp_valid, rsp_res, rsp_zero, rsp_err, req_ready);
                n_fail++;
            end
            tick();
        end
        handshake();
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL cmpeq_release: got v%b r%b want v0 r1",
                     rsp_valid, req_ready);
            n_fail++;
        end
    endtask

    task automatic test_sub_wrap();
        int lat;
        issue(32'd0, 32'd1, 2'b01);
        wait_rsp(lat);
        n_checks++;
        if (lat !== 5 || rsp_res !== 32'hFFFF_FFFF || rsp_zero !== 1'b0) begin
            $display("FAIL sub_wrap: got lat %0d %h z%b want 5 ffffffff z0",
                     lat, rsp_res, rsp_zero);
            n_fail++;
        end
        handshake();
    endtask

    task automatic test_illegal();
        int lat;
        issue(32'd9, 32'd3, 2'b11);
        wait_rsp(lat);
        n_checks++;
        if (lat !== 1) begin
            $display("FAIL illegal_latency: got %0d want 1", lat);
            n_fail++;
        end
        n_checks++;
        if (rsp_err !== 1'b1 || rsp_res !== 32'd0 ||
            rsp_zero !== 1'b0 || alu_ctrl !== 4'd0) begin
            $display("FAIL illegal_rsp: got e%b %h z%b ctrl %0d want e1 0 z0 ctrl 0",
                     rsp_err, rsp_res, rsp_zero, alu_ctrl);
            n_fail++;
        end
        handshake();
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        issue(32'd3, 32'd4, 2'b00);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({alu_a, alu_b, alu_ctrl, rsp_res} !== 100'd0 ||
            {rsp_valid, rsp_zero, rsp_err, req_ready} !== 4'b0001) begin
            $display("FAIL abort_reset: got a %0d b %0d res %0d v%b r%b want 0 0 0 v0 r1",
                     alu_a, alu_b, rsp_res, rsp_valid, req_ready);
            n_fail++;
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen++;
            tick();
        end
        n_checks++;
        if (seen !== 0) begin
            $display("FAIL abort_no_rsp: got %0d valid cycles want 0", seen);
            n_fail++;
        end
        issue(32'd1, 32'd1, 2'b00);
        wait_rsp(lat);
        n_checks++;
        if (lat !== 5 || rsp_res !== 32'd2) begin
            $display("FAIL abort_recover: got lat %0d res %0d want 5 2",
                     lat, rsp_res);
            n_fail++;
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int lat;
        req_a     = 32'd10;
        req_b     = 32'd20;
        req_op    = 2'b00;
        req_valid = 1'b1;
        tick();
        req_a  = 32'd100;
        req_b  = 32'd200;
        req_op = 2'b01;
        wait_rsp(lat);
        n_checks++;
        if (lat !== 5 || rsp_res !== 32'd30 || alu_a !== 32'd10) begin
            $display("FAIL b2b_first: got lat %0d res %0d a %0d want 5 30 10",
                     lat, rsp_res, alu_a);
            n_fail++;
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_res !== 32'd30 || alu_b !== 32'd20) begin
            $display("FAIL b2b_hold: got v%b res %0d b %0d want v1 30 20",
                     rsp_valid, rsp_res, alu_b);
            n_fail++;
        end
        handshake();
        n_checks++;
        if (req_ready !== 1'b1 || alu_a !== 32'd10) begin
            $display("FAIL b2b_idle: got r%b a %0d want r1 10", req_ready, alu_a);
            n_fail++;
        end
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (alu_a !== 32'd100 || alu_b !== 32'd200 || alu_ctrl !== 4'd1) begin
            $display("FAIL b2b_second_accept: got a %0d b %0d ctrl %0d want 100 200 1",
                     alu_a, alu_b, alu_ctrl);
            n_fail++;
        end
        wait_rsp(lat);
        n_checks++;
        if (lat !== 5 || rsp_res !== 32'hFFFF_FF9C) begin
            $display("FAIL b2b_second_rsp: got lat %0d %h want 5 ffffff9c",
                     lat, rsp_res);
            n_fail++;
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_add();
        test_cmpeq_stall();
        test_sub_wrap();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
